// File: rtl/banked_dp_mem.sv
// Banked dual-port memory: NBANKS true-dual-port RAM banks, with request/valid handshake, collision arbitration, cross-port bypass and out-of-range reporting.
// Define BANKED_MEM_OUTREG_EN to add an output register stage (read latency 2).
module banked_dp_mem #(
  parameter int DATA      = 18,
  parameter int BANK_ADDR = 10,
  parameter int NBANKS    = 11,
  parameter int SEL_W     = 4,
  localparam int AW       = SEL_W + BANK_ADDR
) (
  input  logic            clka,
  input  logic            rstn,
  input  logic            a_en,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  output logic            a_valid,
  input  logic            b_en,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout,
  output logic            b_valid,
  output logic            collision,
  output logic            err_oob,
  output logic [7:0]      oob_count
);

  typedef struct packed {
    logic             a_vld;
    logic             b_vld;
    logic             a_oob;
    logic             b_oob;
    logic             a_byp;
    logic             b_byp;
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;
    logic [DATA-1:0]  a_bypd;
    logic [DATA-1:0]  b_bypd;
    logic             coll;
    logic             err;
  } req_t;

  logic [SEL_W-1:0]     a_sel, b_sel;
  logic [BANK_ADDR-1:0] a_idx, b_idx;
  logic                 a_oob, b_oob, same_addr;
  logic                 a_wr, a_rd, b_wr_req, b_wr, b_rd, coll;
  logic [8:0]           cnt_sum;
  logic [7:0]           cnt_d, cnt_q;
  req_t                 req_d, req_q;
  logic [DATA-1:0]      a_rdata, b_rdata;
  logic [DATA-1:0]      a_bank_rd [2**SEL_W];
  logic [DATA-1:0]      b_bank_rd [2**SEL_W];

  always_comb begin
    a_sel     = a_addr[AW-1:BANK_ADDR];
    b_sel     = b_addr[AW-1:BANK_ADDR];
    a_idx     = a_addr[BANK_ADDR-1:0];
    b_idx     = b_addr[BANK_ADDR-1:0];
    a_oob     = a_en && (32'(a_sel) >= NBANKS);
    b_oob     = b_en && (32'(b_sel) >= NBANKS);
    same_addr = (a_addr == b_addr);
    a_wr      = a_en && a_we && !a_oob;
    a_rd      = a_en && !a_we && !a_oob;
    b_wr_req  = b_en && b_we && !b_oob;
    b_rd      = b_en && !b_we && !b_oob;
    // Port A wins a same-address write; B's write is dropped at the bank.
    coll      = a_wr && b_wr_req && same_addr;
    b_wr      = b_wr_req && !coll;

    req_d        = '0;
    req_d.a_vld  = a_en && !a_we;
    req_d.b_vld  = b_en && !b_we;
    req_d.a_oob  = a_oob;
    req_d.b_oob  = b_oob;
    req_d.a_byp  = a_rd && b_wr_req && same_addr;
    req_d.b_byp  = b_rd && a_wr && same_addr;
    req_d.a_sel  = a_sel;
    req_d.b_sel  = b_sel;
    req_d.a_bypd = b_din;
    req_d.b_bypd = a_din;
    req_d.coll   = coll;
    req_d.err    = a_oob || b_oob;

    cnt_sum = {1'b0, cnt_q} + {8'd0, a_oob} + {8'd0, b_oob};
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_bank
    if (g < NBANKS) begin : g_ram
      logic [DATA-1:0] mem [2**BANK_ADDR];
      logic [DATA-1:0] a_rd_q, b_rd_q;
      logic            a_hit, b_hit;

      always_comb begin
        a_hit = (a_sel == SEL_W'(g));
        b_hit = (b_sel == SEL_W'(g));
      end

      always_ff @(posedge clka) begin
        if (a_wr && a_hit) mem[a_idx] <= a_din;
        if (b_wr && b_hit) mem[b_idx] <= b_din;
        if (a_rd && a_hit) a_rd_q <= mem[a_idx];
        if (b_rd && b_hit) b_rd_q <= mem[b_idx];
      end

      assign a_bank_rd[g] = a_rd_q;
      assign b_bank_rd[g] = b_rd_q;
    end else begin : g_none
      assign a_bank_rd[g] = '0;
      assign b_bank_rd[g] = '0;
    end
  end

  // Bypass overrides the bank's read-old value when the other port wrote the same word.
  always_comb begin
    a_rdata = req_q.a_oob ? '0 : (req_q.a_byp ? req_q.a_bypd : a_bank_rd[req_q.a_sel]);
    b_rdata = req_q.b_oob ? '0 : (req_q.b_byp ? req_q.b_bypd : b_bank_rd[req_q.b_sel]);
  end

  assign oob_count = cnt_q;

`ifdef BANKED_MEM_OUTREG_EN
  logic [DATA-1:0] a_out_d, a_out_q, b_out_d, b_out_q;
  logic [3:0]      flg_d, flg_q;

  always_comb begin
    a_out_d = req_q.a_vld ? a_rdata : a_out_q;
    b_out_d = req_q.b_vld ? b_rdata : b_out_q;
    flg_d   = {req_q.a_vld, req_q.b_vld, req_q.coll, req_q.err};
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      a_out_q <= '0;
      b_out_q <= '0;
      flg_q   <= '0;
    end else begin
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      flg_q   <= flg_d;
    end
  end

  assign a_dout    = a_out_q;
  assign b_dout    = b_out_q;
  assign a_valid   = flg_q[3];
  assign b_valid   = flg_q[2];
  assign collision = flg_q[1];
  assign err_oob   = flg_q[0];
`else
  logic [DATA-1:0] a_hold_d, a_hold_q, b_hold_d, b_hold_q;

  always_comb begin
    a_hold_d = req_q.a_vld ? a_rdata : a_hold_q;
    b_hold_d = req_q.b_vld ? b_rdata : b_hold_q;
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
    end
  end

  assign a_dout    = a_hold_d;
  assign b_dout    = b_hold_d;
  assign a_valid   = req_q.a_vld;
  assign b_valid   = req_q.b_vld;
  assign collision = req_q.coll;
  assign err_oob   = req_q.err;
`endif

endmodule
